// File: rtl/tdm_rx_deframer.sv
// ST-bus receive deframer: oversamples c4/f0/data in the clk50 domain, locks to the frame pulse
// and emits one MSB-first byte per channel. Optional length checking under TDM_RX_FRAME_CHECK_EN.
module tdm_rx_deframer #(
    parameter int CHANNELS = 32,
    parameter int CW       = 5
) (
    input  logic          clk50,
    input  logic          reset_n,
    input  logic          c4,
    input  logic          f0,
    input  logic          data_from_dt,
    output logic [7:0]    rx_data,
    output logic [CW-1:0] rx_chan,
    output logic          rx_valid,
    output logic          frame_start,
    output logic          locked,
    output logic          frame_err
);

    localparam int N  = CHANNELS * 16;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCKED = 2'd1,
        RELOCK = 2'd2
    } state_t;

    // Three stages per pin keep c4, f0 and data mutually aligned; stage 2 of c4 feeds edge detect.
    logic [2:0]    c4_sync_q, c4_sync_d;
    logic [2:0]    f0_sync_q, f0_sync_d;
    logic [2:0]    dat_sync_q, dat_sync_d;
    logic          e_q, e_d;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic [CW-1:0] rx_chan_q, rx_chan_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_err_q, frame_err_d;
    logic          locked_q, locked_d;

    logic [KW-1:0] k_nxt;
    logic          f0_low;
    logic          bit_in;

    assign c4_sync_d  = {c4_sync_q[1:0], c4};
    assign f0_sync_d  = {f0_sync_q[1:0], f0};
    assign dat_sync_d = {dat_sync_q[1:0], data_from_dt};
    assign e_d        = c4_sync_q[1] & ~c4_sync_q[2];

    // f0/data stage 3 lines up with the registered edge strobe e_q.
    assign f0_low = ~f0_sync_q[2];
    assign bit_in = dat_sync_q[2];
    assign k_nxt  = (k_q == KW'(N - 1)) ? '0 : k_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        k_d           = k_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_chan_d     = rx_chan_q;
        rx_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_err_d   = 1'b0;

        case (state_q)
            HUNT: begin
                k_d = '0;
                if (e_q && f0_low) begin
                    state_d       = LOCKED;
                    shift_d       = '0;
                    frame_start_d = 1'b1;
                end
            end

            LOCKED: begin
                if (e_q) begin
                    if (f0_low) begin
`ifdef TDM_RX_FRAME_CHECK_EN
                        if (k_nxt != '0) begin
                            frame_err_d = 1'b1;
                            state_d     = RELOCK;
                        end else begin
                            frame_start_d = 1'b1;
                        end
`else
                        frame_start_d = 1'b1;
`endif
                        k_d     = '0;
                        shift_d = '0;
                    end
`ifdef TDM_RX_FRAME_CHECK_EN
                    else if (k_nxt == '0) begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                        k_d         = '0;
                        shift_d     = '0;
                    end
`endif
                    else begin
                        k_d = k_nxt;
                        if (k_nxt[0]) begin
                            shift_d = {shift_q[5:0], bit_in};
                            // Odd rise 16c+15 carries the LSB of channel c.
                            if (k_nxt[3:0] == 4'hF) begin
                                rx_data_d  = {shift_q, bit_in};
                                rx_chan_d  = CW'(k_nxt >> 4);
                                rx_valid_d = 1'b1;
                            end
                        end
                    end
                end
            end

            // Short frame: the offending marker re-locks one clock after frame_err.
            RELOCK: begin
                state_d       = LOCKED;
                frame_start_d = 1'b1;
            end

            default: state_d = HUNT;
        endcase
    end

    assign locked_d = (state_d == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            c4_sync_q     <= '0;
            f0_sync_q     <= '0;
            dat_sync_q    <= '0;
            e_q           <= 1'b0;
            state_q       <= HUNT;
            k_q           <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_chan_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            c4_sync_q     <= c4_sync_d;
            f0_sync_q     <= f0_sync_d;
            dat_sync_q    <= dat_sync_d;
            e_q           <= e_d;
            state_q       <= state_d;
            k_q           <= k_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_chan_q     <= rx_chan_d;
            rx_valid_q    <= rx_valid_d;
            frame_start_q <= frame_start_d;
            frame_err_q   <= frame_err_d;
            locked_q      <= locked_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_chan     = rx_chan_q;
    assign rx_valid    = rx_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_rx_deframer.sv
// Self-checking bench for tdm_rx_deframer: drives ST-bus frames with random filler and
// compares strobes, bytes and their exact cycle against a rise-level reference model.
module tb_tdm_rx_deframer;

    localparam int CH = 32;
    localparam int CW = 5;
    localparam int N  = CH * 16;

    logic          clk50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          c4 = 1'b0;
    logic          f0 = 1'b1;
    logic          data_from_dt = 1'b0;
    logic [7:0]    rx_data;
    logic [CW-1:0] rx_chan;
    logic          rx_valid;
    logic          frame_start;
    logic          locked;
    logic          frame_err;

    tdm_rx_deframer #(.CHANNELS(CH), .CW(CW)) dut (
        .clk50       (clk50),
        .reset_n     (reset_n),
        .c4          (c4),
        .f0          (f0),
        .data_from_dt(data_from_dt),
        .rx_data     (rx_data),
        .rx_chan     (rx_chan),
        .rx_valid    (rx_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .frame_err   (frame_err)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        int cyc;
        int chan;
        int data;
    } rx_ev_t;

    rx_ev_t     exp_rx[$];
    rx_ev_t     obs_rx[$];
    int         exp_fs[$];
    int         obs_fs[$];
    int         exp_fe[$];
    int         obs_fe[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] tx_bytes [CH];
    bit         m_locked = 1'b0;
    int         m_pos = 0;

    // Passive monitor: logs every strobe with the negedge index at which it is seen.
    always @(negedge clk50) begin
        cyc <= cyc + 1;
        if (rx_valid === 1'b1)
            obs_rx.push_back(rx_ev_t'{cyc: cyc, chan: int'(rx_chan), data: int'(rx_data)});
        if (frame_start === 1'b1) obs_fs.push_back(cyc);
        if (frame_err === 1'b1) obs_fe.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a c4 rise seen at cycle t produces its strobes 4 clocks later.
    task automatic model_rise(input int t, input bit f0_low);
        if (f0_low) begin
`ifdef TDM_RX_FRAME_CHECK_EN
            if (m_locked && m_pos != N - 1) begin
                exp_fe.push_back(t + 4);
                exp_fs.push_back(t + 5);
            end else begin
                exp_fs.push_back(t + 4);
            end
`else
            exp_fs.push_back(t + 4);
`endif
            m_locked = 1'b1;
            m_pos    = 0;
        end else if (m_locked) begin
            m_pos = (m_pos + 1) % N;
`ifdef TDM_RX_FRAME_CHECK_EN
            if (m_pos == 0) begin
                exp_fe.push_back(t + 4);
                m_locked = 1'b0;
            end
`endif
            if (m_locked && (m_pos % 16 == 15))
                exp_rx.push_back(rx_ev_t'{cyc: t + 4, chan: m_pos / 16, data: int'(tx_bytes[m_pos / 16])});
        end
    endtask

    // One c4 period: 5 clocks low (f0/data change here), then 5 clocks high.
    task automatic drive_rise(input bit f0_low, input bit d);
        int t;
        @(negedge clk50);
        c4           = 1'b0;
        f0           = ~f0_low;
        data_from_dt = d;
        repeat (5) @(negedge clk50);
        t  = cyc;
        c4 = 1'b1;
        model_rise(t, f0_low);
        repeat (4) @(negedge clk50);
    endtask

    task automatic send_rises(input bit mark, input int count);
        for (int k = 0; k < count; k++) begin
            bit d;
            if (k % 2 == 1) d = tx_bytes[(k % N) / 16][7 - (k % 16) / 2];
            else            d = 1'($urandom);
            drive_rise(mark && (k == 0), d);
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < CH; c++) tx_bytes[c] = 8'($urandom);
    endtask

    task automatic compare_all(input string tag);
        repeat (8) @(negedge clk50);
        check({tag, " rx count"}, obs_rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < obs_rx.size(); i++) begin
            check($sformatf("%s rx[%0d] cycle", tag, i), obs_rx[i].cyc, exp_rx[i].cyc);
            check($sformatf("%s rx[%0d] chan", tag, i), obs_rx[i].chan, exp_rx[i].chan);
            check($sformatf("%s rx[%0d] data", tag, i), obs_rx[i].data, exp_rx[i].data);
        end
        check({tag, " frame_start count"}, obs_fs.size(), exp_fs.size());
        for (int i = 0; i < exp_fs.size() && i < obs_fs.size(); i++)
            check($sformatf("%s frame_start[%0d] cycle", tag, i), obs_fs[i], exp_fs[i]);
        check({tag, " frame_err count"}, obs_fe.size(), exp_fe.size());
        for (int i = 0; i < exp_fe.size() && i < obs_fe.size(); i++)
            check($sformatf("%s frame_err[%0d] cycle", tag, i), obs_fe[i], exp_fe[i]);
        exp_rx.delete();
        obs_rx.delete();
        exp_fs.delete();
        obs_fs.delete();
        exp_fe.delete();
        obs_fe.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_data"}, rx_data, 0);
        check({tag, " rx_chan"}, rx_chan, 0);
        check({tag, " rx_valid"}, rx_valid, 0);
        check({tag, " frame_start"}, frame_start, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " frame_err"}, frame_err, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk50);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // No frame pulse: stays hunting, nothing emitted
        fill_random();
        send_rises(1'b0, 40);
        compare_all("nofp");
        check("nofp locked", locked, 0);

        // Basic lock with channel c = c ^ A5, then bit order with channel 0 = 80
        for (int c = 0; c < CH; c++) tx_bytes[c] = 8'(c) ^ 8'hA5;
        send_rises(1'b1, N);
        check("basic locked", locked, 1);
        compare_all("basic");
        fill_random();
        tx_bytes[0] = 8'h80;
        send_rises(1'b1, N);
        compare_all("bitorder");

        // Short frame: marker arrives at rise 100 of the current frame
        fill_random();
        send_rises(1'b1, 100);
        fill_random();
        send_rises(1'b1, N);
        compare_all("short");
        check("short locked", locked, 1);

        // Long frame: one frame without f0, then a fresh marker
        fill_random();
        send_rises(1'b1, N);
        fill_random();
        send_rises(1'b0, N);
        check("long locked mid", locked, 32'(m_locked));
        fill_random();
        send_rises(1'b1, N);
        compare_all("long");
        check("long relocked", locked, 1);

        // Async reset during channel 17
        fill_random();
        send_rises(1'b1, 17 * 16 + 6);
        compare_all("prerst");
        check("prerst rx_chan", rx_chan, 16);
        check("prerst rx_data", rx_data, tx_bytes[16]);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("asyncrst");
        m_locked = 1'b0;
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        send_rises(1'b0, N - (17 * 16 + 6));
        compare_all("postrst");
        check("postrst locked", locked, 0);
        fill_random();
        send_rises(1'b1, N);
        compare_all("relock");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
